// File: rtl/number_spawner_if.sv
// Signal bundle between the number spawner, the game control that feeds it and the mover it drives.
// The slave modport belongs to the spawner; the master side feeds it frames and mover feedback.
interface number_spawner_if;
    logic               startOfFrame;
    logic               enable;
    logic               collision;
    logic signed [10:0] topLeftX;
    logic signed [31:0] X_SPEED;
    logic signed [31:0] INITIAL_X;
    logic signed [31:0] INITIAL_Y;
    logic               moverResetN;
    logic               numberActive;
    logic [3:0]         digitValue;
    logic               hitPulse;
    logic [15:0]        spawnCount;

    modport master (
        output startOfFrame, enable, collision, topLeftX,
        input  X_SPEED, INITIAL_X, INITIAL_Y, moverResetN, numberActive,
               digitValue, hitPulse, spawnCount
    );

    modport slave (
        input  startOfFrame, enable, collision, topLeftX,
        output X_SPEED, INITIAL_X, INITIAL_Y, moverResetN, numberActive,
               digitValue, hitPulse, spawnCount
    );
endinterface

// File: rtl/number_spawner.sv
// Frame-driven spawner for the falling-number sprite: picks lane, direction and digit from an LFSR,
// reloads the mover with a one-clock active-low pulse and retires the number on exit or collision.
module number_spawner #(
    parameter int MIN_DELAY     = 8,
    parameter int LANE_Y0       = 64,
    parameter int LANE_PITCH    = 96,
    parameter int LEFT_SPAWN_X  = -32,
    parameter int RIGHT_SPAWN_X = 640,
    parameter int LEFT_LIMIT    = -64,
    parameter int RIGHT_LIMIT   = 672,
    parameter int BASE_SPEED    = 64,
    parameter int SPEED_STEP    = 16,
    parameter int MAX_SPEED     = 256,
    parameter int SPEEDUP_EVERY = 4
) (
    input  logic            clk,
    input  logic            reset,
    number_spawner_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DELAY,
        S_LOAD,
        S_ACTIVE,
        S_RETIRE
    } state_t;

    state_t             r_state, w_stateNext;
    logic [15:0]        r_lfsr, w_lfsrNext;
    logic [7:0]         r_delayCnt, w_delayCnt;
    logic               r_dir, w_dir;
    logic signed [31:0] r_speedMag, w_speedMag;
    logic signed [31:0] r_xSpeed, w_xSpeed;
    logic signed [31:0] r_initX, w_initX;
    logic signed [31:0] r_initY, w_initY;
    logic               r_moverResetN, w_moverResetN;
    logic               r_numberActive, w_numberActive;
    logic               r_hitPulse, w_hitPulse;
    logic [3:0]         r_digit, w_digit;
    logic [15:0]        r_spawnCount, w_spawnCount;

    logic signed [31:0] w_topLeftX32;
    logic signed [31:0] w_laneY;
    logic signed [31:0] w_speedSum;
    logic [7:0]         w_newDelay;
    logic [3:0]         w_rawDigit;
    logic               w_outOfBounds;
    logic               w_speedupDue;

    assign w_topLeftX32  = {{21{bus.topLeftX[10]}}, bus.topLeftX};
    assign w_outOfBounds = r_dir ? (w_topLeftX32 > RIGHT_LIMIT) : (w_topLeftX32 < LEFT_LIMIT);
    assign w_newDelay    = 8'(MIN_DELAY) + {4'b0, r_lfsr[3:0]};
    assign w_laneY       = LANE_Y0 + $signed({30'b0, r_lfsr[5:4]}) * LANE_PITCH;
    assign w_rawDigit    = r_lfsr[10:7];
    assign w_speedSum    = r_speedMag + SPEED_STEP;
    assign w_speedupDue  = (r_spawnCount % 16'(SPEEDUP_EVERY)) == 16'd0;

    always_comb begin
        w_stateNext    = r_state;
        w_lfsrNext     = bus.startOfFrame ? {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]}
                                          : r_lfsr;
        w_delayCnt     = r_delayCnt;
        w_dir          = r_dir;
        w_speedMag     = r_speedMag;
        w_xSpeed       = r_xSpeed;
        w_initX        = r_initX;
        w_initY        = r_initY;
        w_moverResetN  = 1'b1;
        w_numberActive = r_numberActive;
        w_hitPulse     = 1'b0;
        w_digit        = r_digit;
        w_spawnCount   = r_spawnCount;

        // Speed-up is earned on the RETIRE clock even if enable drops in the same cycle.
        if (r_state == S_RETIRE && w_speedupDue)
            w_speedMag = (w_speedSum > MAX_SPEED) ? MAX_SPEED : w_speedSum;

        if (!bus.enable) begin
            w_stateNext    = S_IDLE;
            w_numberActive = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_stateNext = S_WAIT_DELAY;
                    w_delayCnt  = w_newDelay;
                end
                S_WAIT_DELAY: begin
                    if (bus.startOfFrame) begin
                        if (r_delayCnt == 8'd0) begin
                            w_stateNext   = S_LOAD;
                            w_initY       = w_laneY;
                            w_dir         = r_lfsr[6];
                            w_initX       = r_lfsr[6] ? LEFT_SPAWN_X : RIGHT_SPAWN_X;
                            w_xSpeed      = r_lfsr[6] ? r_speedMag : -r_speedMag;
                            w_digit       = (w_rawDigit >= 4'd10) ? w_rawDigit - 4'd10 : w_rawDigit;
                            w_moverResetN = 1'b0;
                            w_spawnCount  = r_spawnCount + 16'd1;
                        end else begin
                            w_delayCnt = r_delayCnt - 8'd1;
                        end
                    end
                end
                S_LOAD: begin
                    w_stateNext    = S_ACTIVE;
                    w_numberActive = 1'b1;
                end
                S_ACTIVE: begin
                    if (bus.collision || w_outOfBounds) begin
                        w_stateNext    = S_RETIRE;
                        w_numberActive = 1'b0;
                        w_hitPulse     = bus.collision;
                    end
                end
                S_RETIRE: begin
                    w_stateNext = S_WAIT_DELAY;
                    w_delayCnt  = w_newDelay;
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_lfsr         <= 16'hACE1;
            r_delayCnt     <= '0;
            r_dir          <= 1'b0;
            r_speedMag     <= BASE_SPEED;
            r_xSpeed       <= '0;
            r_initX        <= LEFT_SPAWN_X;
            r_initY        <= LANE_Y0;
            r_moverResetN  <= 1'b1;
            r_numberActive <= 1'b0;
            r_hitPulse     <= 1'b0;
            r_digit        <= '0;
            r_spawnCount   <= '0;
        end else begin
            r_state        <= w_stateNext;
            r_lfsr         <= w_lfsrNext;
            r_delayCnt     <= w_delayCnt;
            r_dir          <= w_dir;
            r_speedMag     <= w_speedMag;
            r_xSpeed       <= w_xSpeed;
            r_initX        <= w_initX;
            r_initY        <= w_initY;
            r_moverResetN  <= w_moverResetN;
            r_numberActive <= w_numberActive;
            r_hitPulse     <= w_hitPulse;
            r_digit        <= w_digit;
            r_spawnCount   <= w_spawnCount;
        end
    end

    assign bus.X_SPEED      = r_xSpeed;
    assign bus.INITIAL_X    = r_initX;
    assign bus.INITIAL_Y    = r_initY;
    assign bus.moverResetN  = r_moverResetN;
    assign bus.numberActive = r_numberActive;
    assign bus.digitValue   = r_digit;
    assign bus.hitPulse     = r_hitPulse;
    assign bus.spawnCount   = r_spawnCount;

endmodule

// File: tb/tb_number_spawner.sv
// Directed bench for number_spawner: a default instance plus a MAX_SPEED=96 instance run in lockstep,
// checked against an LFSR model and hand-derived spawn/retire expectations.
module tb_number_spawner;

    localparam int MIN_DELAY = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    number_spawner_if bus1();
    number_spawner_if bus2();

    number_spawner u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    number_spawner #(.MAX_SPEED(96)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.startOfFrame = bus1.startOfFrame;
    assign bus2.enable       = bus1.enable;
    assign bus2.collision    = bus1.collision;
    assign bus2.topLeftX     = bus1.topLeftX;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic        cur_dir;
    int          g_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h (%0d) expected 0x%h (%0d)", tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int speed_for(input int n, input int max_speed);
        int m;
        m = 64 + 16 * ((n - 1) / 4);
        return (m > max_speed) ? max_speed : m;
    endfunction

    // One clock: drive at a falling edge, land on the next falling edge with outputs settled.
    task automatic step(input logic sof);
        bus1.startOfFrame = sof;
        @(negedge clk);
        m_prev = m_lfsr;
        if (reset)
            m_lfsr = 16'hACE1;
        else if (sof)
            m_lfsr = lfsr_next(m_lfsr);
        bus1.startOfFrame = 1'b0;
    endtask

    task automatic frame();
        step(1'b1);
        repeat (3) step(1'b0);
    endtask

    task automatic run_to_spawn(input int n, input int exp_frames);
        int          frames;
        logic        seen;
        int          ey, ex, es, es2;
        logic [3:0]  dg;
        frames = 0;
        seen   = 1'b0;
        while (!seen && frames < 40) begin
            step(1'b1);
            frames++;
            if (bus1.moverResetN === 1'b0)
                seen = 1'b1;
            else
                repeat (3) step(1'b0);
        end
        check("spawn_seen", 32'(seen), 32'd1);
        check("spawn_delay_frames", frames, exp_frames);
        cur_dir = m_prev[6];
        ey  = 64 + int'(m_prev[5:4]) * 96;
        ex  = cur_dir ? -32 : 640;
        es  = cur_dir ? speed_for(n, 256) : -speed_for(n, 256);
        es2 = cur_dir ? speed_for(n, 96) : -speed_for(n, 96);
        dg  = m_prev[10:7];
        if (dg >= 4'd10) dg = dg - 4'd10;
        check("initial_x", bus1.INITIAL_X, ex);
        check("initial_y", bus1.INITIAL_Y, ey);
        check("x_speed", bus1.X_SPEED, es);
        check("x_speed_sat96", bus2.X_SPEED, es2);
        check("digit", bus1.digitValue, dg);
        check("spawn_count", bus1.spawnCount, n);
        step(1'b0);
        check("reload_pulse_width", bus1.moverResetN, 1'b1);
        check("active_after_load", bus1.numberActive, 1'b1);
    endtask

    task automatic retire_bounds(input logic dir);
        bus1.topLeftX = dir ? 11'sd672 : -11'sd64;
        step(1'b0);
        step(1'b0);
        check("edge_still_active", bus1.numberActive, 1'b1);
        bus1.topLeftX = dir ? 11'sd673 : -11'sd65;
        step(1'b0);
        check("exit_inactive", bus1.numberActive, 1'b0);
        check("exit_no_hit", bus1.hitPulse, 1'b0);
        bus1.topLeftX = 11'sd0;
        g_exp = MIN_DELAY + int'(m_lfsr[3:0]) + 1;
        step(1'b0);
        check("exit_hit_after", bus1.hitPulse, 1'b0);
    endtask

    task automatic retire_hit(input logic dir);
        bus1.topLeftX  = dir ? 11'sd673 : -11'sd65;
        bus1.collision = 1'b1;
        step(1'b0);
        check("hit_pulse", bus1.hitPulse, 1'b1);
        check("hit_inactive", bus1.numberActive, 1'b0);
        bus1.collision = 1'b0;
        bus1.topLeftX  = 11'sd0;
        g_exp = MIN_DELAY + int'(m_lfsr[3:0]) + 1;
        step(1'b0);
        check("hit_pulse_width", bus1.hitPulse, 1'b0);
    endtask

    initial begin
        reset             = 1'b1;
        bus1.enable       = 1'b0;
        bus1.collision    = 1'b0;
        bus1.topLeftX     = 11'sd0;
        bus1.startOfFrame = 1'b0;
        m_lfsr            = 16'hACE1;
        m_prev            = 16'hACE1;
        cur_dir           = 1'b0;
        g_exp             = 0;
        @(negedge clk);
        step(1'b0);
        step(1'b0);
        check("rst_moverResetN", bus1.moverResetN, 1'b1);
        check("rst_numberActive", bus1.numberActive, 1'b0);
        check("rst_spawnCount", bus1.spawnCount, 16'd0);
        check("rst_x_speed", bus1.X_SPEED, 32'd0);
        check("rst_initial_x", bus1.INITIAL_X, 32'hFFFF_FFE0);
        check("rst_initial_y", bus1.INITIAL_Y, 32'd64);
        check("rst_digit", bus1.digitValue, 4'd0);
        check("rst_hit", bus1.hitPulse, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            frame();
            check("idle_no_reload", bus1.moverResetN, 1'b1);
            check("idle_inactive", bus1.numberActive, 1'b0);
        end
        check("idle_spawnCount", bus1.spawnCount, 16'd0);

        bus1.enable = 1'b1;
        g_exp = MIN_DELAY + int'(m_lfsr[3:0]) + 1;
        step(1'b0);

        for (int n = 1; n <= 20; n++) begin
            run_to_spawn(n, g_exp);
            if (n % 2 == 1)
                retire_bounds(cur_dir);
            else
                retire_hit(cur_dir);
        end

        run_to_spawn(21, g_exp);
        bus1.enable = 1'b0;
        step(1'b0);
        check("dis_inactive", bus1.numberActive, 1'b0);
        check("dis_moverResetN", bus1.moverResetN, 1'b1);
        check("dis_spawnCount_kept", bus1.spawnCount, 16'd21);
        frame();
        frame();
        check("dis_no_reload", bus1.moverResetN, 1'b1);
        bus1.enable = 1'b1;
        g_exp = MIN_DELAY + int'(m_lfsr[3:0]) + 1;
        step(1'b0);
        run_to_spawn(22, g_exp);

        reset = 1'b1;
        step(1'b0);
        check("midrst_inactive", bus1.numberActive, 1'b0);
        check("midrst_moverResetN", bus1.moverResetN, 1'b1);
        check("midrst_spawnCount", bus1.spawnCount, 16'd0);
        check("midrst_x_speed", bus1.X_SPEED, 32'd0);
        reset = 1'b0;
        step(1'b0);
        // 0xACE1 has lfsr[3:0]=1, so the first delay after reset is 8+1+1 frames.
        run_to_spawn(1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
